// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared state encoding and default sizes for the data-memory arbiter
package dm_arbiter_pkg;

  localparam int DM_NUM_CORES = 4;
  localparam int DM_ADDR_W    = 8;
  localparam int DM_DATA_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dm_arbiter_rr.sv
// rtl/dm_arbiter_rr.sv - round-robin single-grant selector with rotating priority pointer
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  int               j;

  // Walk from ptr upward with wrap; the first requester found wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      cand = IDX_W'(j);
      if (en && !gnt_valid && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (gnt_valid) begin
      ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - run-controlled arbiter giving NUM_CORES cores shared access to one data memory port
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int NUM_CORES = DM_NUM_CORES,
  parameter int ADDR_W    = DM_ADDR_W,
  parameter int DATA_W    = DM_DATA_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]        core_done,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy,
  output logic                        all_done
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   all_done_q, all_done_d;
  logic [NUM_CORES-1:0]   done_q, done_d;
  logic [NUM_CORES-1:0]   rvalid_q, rvalid_d;
  logic [NUM_CORES-1:0]   eligible;
  logic [NUM_CORES-1:0]   gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   gnt_valid;
  logic                   arb_en;
  logic                   rd_pend;

  assign rd_pend  = |rvalid_q;
  assign eligible = core_req & ~done_q;
  // Gating with reset keeps grants and in-flight read data off the bus in the reset cycle itself.
  assign arb_en   = (state_q == RUN) && !reset;

  rr_arbiter #(.N(NUM_CORES), .IDX_W(IDX_W)) u_rr (
    .clock    (clock),
    .reset    (reset),
    .en       (arb_en),
    .req      (eligible),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        done_d  = '0;
      end
      RUN: begin
        done_d = done_q | core_done;
        if (&done_q && !rd_pend) state_d = DONE;
      end
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d == RUN);
    all_done_d = (state_d == DONE);
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rvalid_d  = '0;
    if (gnt_valid) begin
      mem_we    = core_we[gnt_idx];
      mem_addr  = core_addr[gnt_idx*ADDR_W +: ADDR_W];
      mem_wdata = core_wdata[gnt_idx*DATA_W +: DATA_W];
      if (!core_we[gnt_idx]) rvalid_d = gnt;
    end
    core_gnt    = gnt;
    core_rvalid = reset ? '0 : rvalid_q;
    core_rdata  = (|core_rvalid) ? mem_rdata : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      all_done_q <= 1'b0;
      done_q     <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      all_done_q <= all_done_d;
      done_q     <= done_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign busy     = busy_q;
  assign all_done = all_done_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed and randomized checks of dm_arbiter against a behavioural model
module tb_dm_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  core_req, core_we, core_done;
  logic [31:0] core_addr;
  logic [63:0] core_wdata;
  logic [3:0]  core_gnt, core_rvalid;
  logic [15:0] core_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        busy, all_done;

  int checks = 0;
  int failures = 0;

  logic [15:0] tb_mem [256];

  // model state: 0 idle, 1 run, 2 done
  int          m_state;
  int          m_ptr;
  logic [3:0]  m_done, m_rv;
  logic [15:0] m_rvdata;

  logic [3:0]  exp_gnt, exp_rv;
  int          exp_idx;
  logic        exp_we, exp_busy, exp_alld;
  logic [7:0]  exp_addr;
  logic [15:0] exp_wdata, exp_rdata;

  dm_arbiter dut (
    .clock(clock), .reset(reset), .start(start),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_done(core_done),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .all_done(all_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr];
  end

  task model_comb();
    int c;
    exp_gnt = 4'b0; exp_idx = 0; exp_we = 1'b0; exp_addr = 8'h0; exp_wdata = 16'h0;
    if (m_state == 1 && !reset) begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (exp_gnt == 4'b0 && core_req[c] && !m_done[c]) begin
          exp_gnt = 4'b0001 << c;
          exp_idx = c;
        end
      end
    end
    if (exp_gnt != 4'b0) begin
      exp_we    = core_we[exp_idx];
      exp_addr  = core_addr[exp_idx*8 +: 8];
      exp_wdata = core_wdata[exp_idx*16 +: 16];
    end
    exp_rv    = reset ? 4'b0 : m_rv;
    exp_rdata = (exp_rv != 4'b0) ? m_rvdata : 16'h0;
    exp_busy  = (m_state == 1);
    exp_alld  = (m_state == 2);
  endtask

  task model_clock();
    logic [3:0] nrv;
    model_comb();
    if (reset) begin
      m_state = 0; m_ptr = 0; m_done = 4'b0; m_rv = 4'b0;
    end else begin
      nrv = 4'b0;
      if (exp_gnt != 4'b0) begin
        m_ptr = (exp_idx + 1) % 4;
        if (!exp_we) begin
          nrv      = exp_gnt;
          m_rvdata = tb_mem[exp_addr];
        end
      end
      case (m_state)
        0: if (start) begin m_state = 1; m_done = 4'b0; end
        1: begin
          if (m_done == 4'hF && m_rv == 4'b0) m_state = 2;
          m_done = m_done | core_done;
        end
        default: if (!start) m_state = 0;
      endcase
      m_rv = nrv;
    end
  endtask

  task tick();
    model_clock();
    @(negedge clock);
  endtask

  task sample();
    #1;
    model_comb();
  endtask

  task clear_inputs();
    start = 1'b0; core_req = 4'b0; core_we = 4'b0; core_done = 4'b0;
    core_addr = 32'h0; core_wdata = 64'h0;
  endtask

  task do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task go_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task test_reset();
    do_reset();
    core_req = 4'hF;
    sample();
    checks++; if (core_gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%h exp=0", core_gnt); end
    checks++; if (core_rvalid !== 4'b0) begin failures++; $display("FAIL reset_rvalid got=%h exp=0", core_rvalid); end
    checks++; if (core_rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", core_rdata); end
    checks++; if ({mem_we, mem_addr, mem_wdata} !== 25'h0) begin failures++; $display("FAIL reset_mem got=%b/%h/%h exp=0", mem_we, mem_addr, mem_wdata); end
    checks++; if ({busy, all_done} !== 2'b00) begin failures++; $display("FAIL reset_status got=%b%b exp=00", busy, all_done); end
  endtask

  task test_idle_masking();
    core_req = 4'hF;
    start = 1'b1;
    sample();
    checks++; if (core_gnt !== 4'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL idle_mask gnt=%h we=%b exp=0/0", core_gnt, mem_we); end
    tick();
    sample();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL idle_to_run busy=%b exp=1", busy); end
    checks++; if (core_gnt !== 4'b0001) begin failures++; $display("FAIL idle_first_gnt got=%h exp=1", core_gnt); end
  endtask

  task test_contention();
    int seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    go_run();
    core_req = 4'hF; core_we = 4'hF;
    for (int i = 0; i < 5; i++) begin
      sample();
      checks++;
      if (core_gnt !== (4'b0001 << seq[i]))
        begin failures++; $display("FAIL contention_%0d got=%h exp=%h", i, core_gnt, 4'b0001 << seq[i]); end
      tick();
    end
    core_req = 4'b0;
  endtask

  task test_single_read();
    do_reset();
    tb_mem[8'h15] = 16'h00AB;
    go_run();
    core_req = 4'b0100; core_we = 4'b0; core_addr[16 +: 8] = 8'h15;
    sample();
    checks++; if (core_gnt !== 4'b0100 || mem_addr !== 8'h15 || mem_we !== 1'b0)
      begin failures++; $display("FAIL read_req gnt=%h addr=%h we=%b exp=4/15/0", core_gnt, mem_addr, mem_we); end
    tick();
    core_req = 4'b0;
    sample();
    checks++; if (core_rvalid !== 4'b0100) begin failures++; $display("FAIL read_rvalid got=%h exp=4", core_rvalid); end
    checks++; if (core_rdata !== 16'h00AB) begin failures++; $display("FAIL read_rdata got=%h exp=00ab", core_rdata); end
    tick();
    sample();
    checks++; if (core_rvalid !== 4'b0) begin failures++; $display("FAIL read_rvalid_once got=%h exp=0", core_rvalid); end
  endtask

  task test_write();
    do_reset();
    go_run();
    core_req = 4'b0010; core_we = 4'b0010; core_addr[8 +: 8] = 8'h40; core_wdata[16 +: 16] = 16'h1234;
    sample();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h40 || mem_wdata !== 16'h1234)
      begin failures++; $display("FAIL write_bus got=%b/%h/%h exp=1/40/1234", mem_we, mem_addr, mem_wdata); end
    tick();
    core_req = 4'b0;
    sample();
    checks++; if (mem_we !== 1'b0 || core_rvalid !== 4'b0)
      begin failures++; $display("FAIL write_after we=%b rvalid=%h exp=0/0", mem_we, core_rvalid); end
  endtask

  task test_completion();
    do_reset();
    tb_mem[8'h33] = 16'hBEEF;
    start = 1'b1;
    tick();
    core_done = 4'b0111;
    tick();
    core_done = 4'b1000; core_req = 4'b1000; core_we = 4'b0; core_addr[24 +: 8] = 8'h33;
    sample();
    checks++; if (core_gnt !== 4'b1000) begin failures++; $display("FAIL done_same_cycle_gnt got=%h exp=8", core_gnt); end
    tick();
    core_done = 4'b0; core_req = 4'b0;
    sample();
    checks++; if (core_rvalid !== 4'b1000 || core_rdata !== 16'hBEEF)
      begin failures++; $display("FAIL done_rvalid got=%h/%h exp=8/beef", core_rvalid, core_rdata); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL done_pending_busy got=%b exp=1", busy); end
    tick();
    tick();
    core_req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++; if (all_done !== 1'b1 || busy !== 1'b0 || core_gnt !== 4'b0)
        begin failures++; $display("FAIL done_hold_%0d all_done=%b busy=%b gnt=%h exp=1/0/0", i, all_done, busy, core_gnt); end
      tick();
    end
    start = 1'b0;
    tick();
    sample();
    checks++; if (all_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL done_to_idle all_done=%b busy=%b exp=0/0", all_done, busy); end
  endtask

  task test_reset_mid_read();
    do_reset();
    go_run();
    core_req = 4'b0001; core_we = 4'b0;
    tick();
    tick();
    core_req = 4'b0010;
    sample();
    checks++; if (core_gnt !== 4'b0010) begin failures++; $display("FAIL midread_gnt got=%h exp=2", core_gnt); end
    tick();
    reset = 1'b1; core_req = 4'b0;
    sample();
    checks++; if (core_rvalid !== 4'b0 || core_rdata !== 16'h0)
      begin failures++; $display("FAIL midread_rvalid got=%h/%h exp=0/0", core_rvalid, core_rdata); end
    tick();
    reset = 1'b0;
    sample();
    checks++; if (busy !== 1'b0 || core_rvalid !== 4'b0) begin failures++; $display("FAIL midread_idle busy=%b rvalid=%h exp=0/0", busy, core_rvalid); end
    start = 1'b1;
    tick();
    start = 1'b0; core_req = 4'hF; core_we = 4'hF;
    sample();
    checks++; if (core_gnt !== 4'b0001) begin failures++; $display("FAIL midread_ptr_reset got=%h exp=1", core_gnt); end
    core_req = 4'b0;
  endtask

  task test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      start      = ($urandom_range(0, 9) < 4);
      core_req   = 4'($urandom);
      core_we    = 4'($urandom);
      core_addr  = $urandom;
      core_wdata = {$urandom, $urandom};
      core_done  = 4'b0;
      for (int c = 0; c < 4; c++) if ($urandom_range(0, 11) == 0) core_done[c] = 1'b1;
      sample();
      checks++;
      if (core_gnt !== exp_gnt || mem_we !== exp_we || mem_addr !== exp_addr || mem_wdata !== exp_wdata)
        begin failures++; $display("FAIL rand_grant_%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", n, core_gnt, mem_we, mem_addr, mem_wdata, exp_gnt, exp_we, exp_addr, exp_wdata); end
      checks++;
      if (core_rvalid !== exp_rv || core_rdata !== exp_rdata)
        begin failures++; $display("FAIL rand_read_%0d got=%h/%h exp=%h/%h", n, core_rvalid, core_rdata, exp_rv, exp_rdata); end
      checks++;
      if (busy !== exp_busy || all_done !== exp_alld)
        begin failures++; $display("FAIL rand_status_%0d got=%b/%b exp=%b/%b", n, busy, all_done, exp_busy, exp_alld); end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    m_state = 0; m_ptr = 0; m_done = 4'b0; m_rv = 4'b0; m_rvdata = 16'h0;
    for (int a = 0; a < 256; a++) tb_mem[a] = 16'($urandom);
    @(negedge clock);
    test_reset();
    test_idle_masking();
    test_contention();
    test_single_read();
    test_write();
    test_completion();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
